// File: rtl/ex_pipe.sv
// ex_pipe: registered execute stage between ID and MEM with ALU, carry flag, forwarding, branches and back-pressure.
// Define EX_FWD2_EN to add distance-2 (S2) forwarding and the one-cycle load-use stall.
module ex_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              aluClk,
  input  logic              aluReset,
  input  logic              iValid_ID,
  output logic              oReady_ID,
  input  logic              iFlush,
  input  logic [DATA_W-1:0] iAcumA,
  input  logic [DATA_W-1:0] iAcumB,
  input  logic [DATA_W-1:0] iConst,
  input  logic [1:0]        outSelMuxExe,
  input  logic [5:0]        iAluInstSel,
  input  logic [ADDR_W-1:0] branchDir_ID,
  input  logic [2:0]        iControlAcum_ID,
  input  logic [1:0]        iMemControl_ID,
  input  logic [DATA_W-1:0] iMemData_MEM,
  input  logic              iReady_MEM,
  output logic              oValid_EX,
  output logic              branchTaken,
  output logic [DATA_W-1:0] oAluData,
  output logic [ADDR_W-1:0] branchDir_EX,
  output logic [2:0]        oControlAcum_EX,
  output logic [1:0]        oMemControl_EX,
  output logic [5:0]        oInstr_EX,
  output logic              oCarry
);

  localparam logic [5:0] OP_ADDA = 6'd1,  OP_ADDB = 6'd2,  OP_ADDCA = 6'd3,  OP_ADDCB = 6'd4;
  localparam logic [5:0] OP_SUBA = 6'd5,  OP_SUBB = 6'd6,  OP_SUBCA = 6'd7,  OP_SUBCB = 6'd8;
  localparam logic [5:0] OP_ANDA = 6'd9,  OP_ANDB = 6'd10, OP_ANDCA = 6'd11, OP_ANDCB = 6'd12;
  localparam logic [5:0] OP_ORA  = 6'd13, OP_ORB  = 6'd14, OP_ORCA  = 6'd15, OP_ORCB  = 6'd16;
  localparam logic [5:0] OP_ASLA = 6'd17, OP_ASRA = 6'd18, OP_JMP   = 6'd19;
  localparam logic [5:0] OP_BAEQ = 6'd20, OP_BANE = 6'd21, OP_BAMI  = 6'd22;
  localparam logic [5:0] OP_BAPL = 6'd23, OP_BACS = 6'd24, OP_BACC  = 6'd25;
  localparam logic [5:0] OP_BBEQ = 6'd26, OP_BBNE = 6'd27, OP_BBMI  = 6'd28;
  localparam logic [5:0] OP_BBPL = 6'd29, OP_BBCS = 6'd30, OP_BBCC  = 6'd31;
  localparam logic [2:0] CTL_A_CONST = 3'b001, CTL_A_RES = 3'b010;
  localparam logic [2:0] CTL_B_CONST = 3'b011, CTL_B_RES = 3'b100;
  localparam logic [1:0] MEM_LOAD = 2'b01;

  function automatic logic wr_a(input logic [2:0] c);
    return (c == CTL_A_CONST) || (c == CTL_A_RES);
  endfunction

  function automatic logic wr_b(input logic [2:0] c);
    return (c == CTL_B_CONST) || (c == CTL_B_RES);
  endfunction

  logic              valid_q, valid_d, taken_q, taken_d, carry_q, carry_d;
  logic [DATA_W-1:0] alu_q, alu_d, wval_q, wval_d;
  logic [ADDR_W-1:0] dir_q, dir_d;
  logic [2:0]        ctl_q, ctl_d;
  logic [1:0]        mem_q, mem_d;
  logic [5:0]        instr_q, instr_d;

  logic              advance_c, stall_c, accept_c;
  logic [DATA_W-1:0] hist_a_c, hist_b_c, fwd_a_c, fwd_b_c, op1_c, op2_c, res_c, wval_c;
  logic [DATA_W:0]   ext_c;
  logic              cy_c, cy_en_c, take_c;

  assign advance_c = iReady_MEM | ~valid_q;
  assign oReady_ID = advance_c & ~stall_c;
  assign accept_c  = iValid_ID & oReady_ID & ~iFlush;

`ifdef EX_FWD2_EN
  logic              s2_valid_q, s2_valid_d;
  logic [2:0]        s2_ctl_q, s2_ctl_d;
  logic [DATA_W-1:0] s2_val_q, s2_val_d;
  logic              reads_a_c, reads_b_c;

  assign reads_a_c = outSelMuxExe[0] | (iAluInstSel == OP_ASLA) | (iAluInstSel == OP_ASRA) |
                     ((iAluInstSel >= OP_BAEQ) && (iAluInstSel <= OP_BACC));
  assign reads_b_c = outSelMuxExe[1] | ((iAluInstSel >= OP_BBEQ) && (iAluInstSel <= OP_BBCC));
  // A flushed instruction never waits, so the stall drops with iFlush.
  assign stall_c = valid_q & (mem_q == MEM_LOAD) & iValid_ID & ~iFlush &
                   ((wr_a(ctl_q) & reads_a_c) | (wr_b(ctl_q) & reads_b_c));
  assign hist_a_c = (s2_valid_q & wr_a(s2_ctl_q)) ? s2_val_q : iAcumA;
  assign hist_b_c = (s2_valid_q & wr_b(s2_ctl_q)) ? s2_val_q : iAcumB;

  // History moves only with the EX register, so it never runs ahead of S1.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_ctl_d   = s2_ctl_q;
    s2_val_d   = s2_val_q;
    if (advance_c) begin
      s2_valid_d = valid_q;
      s2_ctl_d   = ctl_q;
      s2_val_d   = (mem_q == MEM_LOAD) ? iMemData_MEM : wval_q;
    end
  end

  always_ff @(posedge aluClk or negedge aluReset) begin
    if (!aluReset) begin
      s2_valid_q <= 1'b0;
      s2_ctl_q   <= '0;
      s2_val_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_ctl_q   <= s2_ctl_d;
      s2_val_q   <= s2_val_d;
    end
  end
`else
  logic unused_mem_c;
  assign unused_mem_c = ^iMemData_MEM;
  assign stall_c  = 1'b0;
  assign hist_a_c = iAcumA;
  assign hist_b_c = iAcumB;
`endif

  // Loads in S1 have no data yet and are never forwarded from there.
  assign fwd_a_c = (valid_q & wr_a(ctl_q) & (mem_q != MEM_LOAD)) ? wval_q : hist_a_c;
  assign fwd_b_c = (valid_q & wr_b(ctl_q) & (mem_q != MEM_LOAD)) ? wval_q : hist_b_c;
  assign op1_c   = outSelMuxExe[0] ? fwd_a_c : iConst;
  assign op2_c   = outSelMuxExe[1] ? fwd_b_c : iConst;

  always_comb begin
    res_c   = op1_c;
    ext_c   = '0;
    cy_c    = 1'b0;
    cy_en_c = 1'b0;
    case (iAluInstSel)
      OP_ADDA, OP_ADDB, OP_ADDCA, OP_ADDCB: begin
        ext_c   = {1'b0, op1_c} + {1'b0, op2_c};
        res_c   = ext_c[DATA_W-1:0];
        cy_c    = ext_c[DATA_W];
        cy_en_c = 1'b1;
      end
      OP_SUBA, OP_SUBB, OP_SUBCA, OP_SUBCB: begin
        ext_c   = {1'b0, op1_c} - {1'b0, op2_c};
        res_c   = ext_c[DATA_W-1:0];
        cy_c    = ext_c[DATA_W];
        cy_en_c = 1'b1;
      end
      OP_ANDA, OP_ANDB, OP_ANDCA, OP_ANDCB: res_c = op1_c & op2_c;
      OP_ORA, OP_ORB, OP_ORCA, OP_ORCB:     res_c = op1_c | op2_c;
      OP_ASLA: begin
        res_c   = {fwd_a_c[DATA_W-2:0], 1'b0};
        cy_c    = fwd_a_c[DATA_W-1];
        cy_en_c = 1'b1;
      end
      OP_ASRA: begin
        res_c   = {1'b0, fwd_a_c[DATA_W-1:1]};
        cy_c    = fwd_a_c[0];
        cy_en_c = 1'b1;
      end
      default: res_c = op1_c;
    endcase
  end

  // carry_q already includes the instruction sitting in S1.
  always_comb begin
    take_c = 1'b0;
    case (iAluInstSel)
      OP_JMP:  take_c = 1'b1;
      OP_BAEQ: take_c = (op1_c == '0);
      OP_BANE: take_c = (op1_c != '0);
      OP_BAMI: take_c = op1_c[DATA_W-1];
      OP_BAPL: take_c = ~op1_c[DATA_W-1];
      OP_BACS: take_c = carry_q;
      OP_BACC: take_c = ~carry_q;
      OP_BBEQ: take_c = (op2_c == '0);
      OP_BBNE: take_c = (op2_c != '0);
      OP_BBMI: take_c = op2_c[DATA_W-1];
      OP_BBPL: take_c = ~op2_c[DATA_W-1];
      OP_BBCS: take_c = carry_q;
      OP_BBCC: take_c = ~carry_q;
      default: take_c = 1'b0;
    endcase
  end

  assign wval_c = ((iControlAcum_ID == CTL_A_CONST) || (iControlAcum_ID == CTL_B_CONST)) ? iConst : res_c;

  always_comb begin
    valid_d = valid_q;
    taken_d = taken_q;
    alu_d   = alu_q;
    wval_d  = wval_q;
    dir_d   = dir_q;
    ctl_d   = ctl_q;
    mem_d   = mem_q;
    instr_d = instr_q;
    carry_d = carry_q;
    if (advance_c) begin
      valid_d = accept_c;
      taken_d = accept_c & take_c;
      ctl_d   = accept_c ? iControlAcum_ID : 3'b000;
      mem_d   = accept_c ? iMemControl_ID : 2'b00;
    end
    if (accept_c) begin
      alu_d   = res_c;
      wval_d  = wval_c;
      dir_d   = branchDir_ID;
      instr_d = iAluInstSel;
      if (cy_en_c) carry_d = cy_c;
    end
  end

  always_ff @(posedge aluClk or negedge aluReset) begin
    if (!aluReset) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      alu_q   <= '0;
      wval_q  <= '0;
      dir_q   <= '0;
      ctl_q   <= '0;
      mem_q   <= '0;
      instr_q <= '0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      taken_q <= taken_d;
      alu_q   <= alu_d;
      wval_q  <= wval_d;
      dir_q   <= dir_d;
      ctl_q   <= ctl_d;
      mem_q   <= mem_d;
      instr_q <= instr_d;
      carry_q <= carry_d;
    end
  end

  assign oValid_EX       = valid_q;
  assign branchTaken     = taken_q;
  assign oAluData        = alu_q;
  assign branchDir_EX    = dir_q;
  assign oControlAcum_EX = ctl_q;
  assign oMemControl_EX  = mem_q;
  assign oInstr_EX       = instr_q;
  assign oCarry          = carry_q;

endmodule

// File: doc/ex_pipe.md
# ex_pipe

Parametrised, registered execute stage for the accumulator pipeline. It sits between ID and MEM. It performs ALU operations on the two accumulators or the constant at a configurable data width. It forwards results from the two previous instructions, inserts a one-cycle load-use stall, keeps a carry flag, resolves branches and supports valid/ready back-pressure from MEM.

## Interface
- DATA_W, 8, accumulator/constant/result width (≥4)
- ADDR_W, 10, branch/store address width
- aluClk  in  1  clock, all state on rising edge
- aluReset  in  1  asynchronous, active-low reset
- iValid_ID  in  1  ID presents an instruction
- oReady_ID  out  1  EX accepts this cycle (combinational)
- iFlush  in  1  kill the instruction presented this cycle
- iAcumA, iAcumB  in  DATA_W  accumulator values read in ID
- iConst  in  DATA_W  immediate
- outSelMuxExe  in  2  bit0: op1 = A (1) / const (0); bit1: op2 = B (1) / const (0)
- iAluInstSel  in  6  opcode, encoded per instrDefine.v
- branchDir_ID  in  ADDR_W  target / store address
- iControlAcum_ID  in  3  000 none, 001 A←const, 010 A←result, 011 B←const, 100 B←result
- iMemControl_ID  in  2  00 none, 01 load, 10 store
- iMemData_MEM  in  DATA_W  load data returned by MEM for the instruction leaving the EX register
- iReady_MEM  in  1  MEM accepts the EX register
- oValid_EX, branchTaken  out  1  registered
- oAluData  out  DATA_W; branchDir_EX  out  ADDR_W; oControlAcum_EX  out  3; oMemControl_EX  out  2; oInstr_EX  out  6; oCarry  out  1

## Operation
- Accept = iValid_ID & oReady_ID & ~iFlush. Advance = iReady_MEM | ~oValid_EX. oReady_ID = advance & ~stall.
- Operand path: raw value (iAcumA/iAcumB), overridden by forwarding, then selected against iConst by outSelMuxExe.
- Forwarding priority:
  - S1 (EX register) if valid, it writes that accumulator (001/010 for A, 011/100 for B), and it is not a load.
  - Otherwise S2 (history).
  - Otherwise raw.
- Write value: const for 001/011, ALU result for 010/100.
- S2 captures S1 on every advance. For a load it captures iMemData_MEM instead of oAluData.
- Stall: S1 is a valid load and the incoming valid instruction reads that accumulator → oReady_ID=0 for exactly one cycle. A bubble enters the EX register, and the load moves to S2.
- ALU, modulo 2^DATA_W:
  - ADD/SUB/AND/OR: op1 ∘ op2. For the *B variants, the result goes to B.
  - ASLA: C←msb, result = A<<1.
  - ASRA: C←lsb, result = A>>1 (logical).
  - ADD sets C = carry out; SUB sets C = borrow.
  - Other opcodes: result = op1, and C is unchanged.
- Branches, evaluated on forwarded operands:
  - JMP always taken.
  - xEQ: operand == 0; xNE: operand != 0; xMI: msb = 1; xPL: msb = 0; xCS: C = 1; xCC: C = 0.
  - xA uses op1, xB uses op2.
  - The C checked is the flag value including the instruction in S1.
- branchDir_EX, oControlAcum_EX, oMemControl_EX and oInstr_EX are registered copies of their ID inputs.

## Timing
- Latency is 1 cycle: an instruction accepted at edge n is visible on the outputs after edge n.
- The EX register holds while ~advance. Outputs are stable while oValid_EX=1 & iReady_MEM=0.
- A bubble (~accept & advance) clears oValid_EX, branchTaken, oControlAcum_EX and oMemControl_EX. The other fields are don't-care.
- Reset (async assert): every output register = 0, C = 0, S2 invalid. oReady_ID = 1 once reset is released.
- Reset mid-stall: the stall is abandoned, and the instruction must be re-presented.
- iFlush together with a stall: iFlush wins, and the stall clears.
- Back-pressure during a load-use: the stall is held until advance. Forwarding is never taken from stale S2 data.

## Configuration
- EX_FWD2_EN defined: S2 forwarding and the load-use stall are present.
- Undefined: only S1 forwarding of non-loads. No stall logic, and oReady_ID = advance. Software must place 2 NOPs after a load and 1 NOP between distance-2 dependents.

## Test plan
- LDCA 5; ADDCA 3; ADDCA 1, back to back → oAluData 8 then 9, with no bubbles.
- LDCA 0x80; ASLA; BACS → C=1, oAluData=0x00, branchTaken=1.
- LDA (iMemData_MEM=0x22); ADDCA 1 → one bubble, oReady_ID low for 1 cycle, oAluData=0x23.
- ADDCB with iReady_MEM low for 3 cycles → outputs frozen, oReady_ID=0, no instruction lost or duplicated.
- iFlush during an accept → oValid_EX=0 next cycle, and S2 keeps the previous instruction.
- Reset asserted mid-stream → all outputs 0 asynchronously, C=0, and the first post-reset ADDA uses raw accumulators.
